// File: rtl/i2s_rx.sv
// I2S receiver: brings the pad signals into the clk domain, deframes standard
// one-bit-delayed I2S words and offers each left/right pair on a valid/ready port.
module i2s_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             en,
    input  logic             i2s_sclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_sdata,
    output logic [WIDTH-1:0] sample_l,
    output logic [WIDTH-1:0] sample_r,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    input  logic             overflow_clr
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    logic [1:0]       sclk_sync_q, lr_sync_q, sd_sync_q;
    logic             sclk_prev_q;
    logic             lr_prev_q, lr_prev_d;
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] sample_l_q, sample_l_d;
    logic [WIDTH-1:0] sample_r_q, sample_r_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    logic             sclk_rise, lr_now, sd_now, lr_fall, lr_rise;
    logic             frame_done, ovf_set;
    logic [WIDTH-1:0] word_w;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign lr_now    = lr_sync_q[1];
    assign sd_now    = sd_sync_q[1];
    assign lr_fall   = sclk_rise & lr_prev_q & ~lr_now;
    assign lr_rise   = sclk_rise & ~lr_prev_q & lr_now;
    assign lr_prev_d = sclk_rise ? lr_now : lr_prev_q;

    // Current word including the bit on this edge; slots past WIDTH add nothing.
    always_comb begin
        word_w = shift_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q < CNT_MAX && i == WIDTH - 1 - int'(cnt_q)) begin
                word_w[i] = sd_now;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        frame_done = 1'b0;
        if (!en) begin
            state_d = ST_SYNC;
            cnt_d   = '0;
            shift_d = '0;
            hold_d  = '0;
        end else if (sclk_rise) begin
            case (state_q)
                ST_SYNC: begin
                    if (lr_fall) begin
                        state_d = ST_LEFT;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                ST_LEFT: begin
                    if (lr_rise) begin
                        hold_d  = word_w;
                        state_d = ST_RIGHT;
                        cnt_d   = '0;
                        shift_d = '0;
                    end else if (!lr_fall) begin
                        shift_d = word_w;
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RIGHT: begin
                    if (lr_fall) begin
                        frame_done = 1'b1;
                        state_d    = ST_LEFT;
                        cnt_d      = '0;
                        shift_d    = '0;
                    end else if (!lr_rise) begin
                        shift_d = word_w;
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    // A finished frame is accepted unless an unconsumed pair is still on offer.
    always_comb begin
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        valid_d    = valid_q;
        ovf_set    = 1'b0;
        if (frame_done) begin
            if (!valid_q || ready) begin
                sample_l_d = hold_q;
                sample_r_d = word_w;
                valid_d    = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        overflow_d = ovf_set | (overflow_q & ~overflow_clr);
    end

    // NOTE: data registers are reset too, so outputs read 0 the moment arstn falls.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            state_q     <= ST_SYNC;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], i2s_sclk};
            lr_sync_q   <= {lr_sync_q[0], i2s_lrclk};
            sd_sync_q   <= {sd_sync_q[0], i2s_sdata};
            sclk_prev_q <= sclk_sync_q[1];
            lr_prev_q   <= lr_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sample_l = sample_l_q;
    assign sample_r = sample_r_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
- REQ-001: Parameter WIDTH, default 16, meaning the sample width per channel in bits (legal range 8..32).
- REQ-002: clk  input  1  is the system clock; all state is updated on its rising edge.
- REQ-003: arstn  input  1  is the reset, asynchronous and active-low.
- REQ-004: en  input  1  enables the receiver; when low, the receiver is held in SYNC.
- REQ-005: i2s_sclk  input  1  is the external bit clock from the pad, asynchronous to clk.
- REQ-006: i2s_lrclk  input  1  is the external word select from the pad (0 = left, 1 = right), asynchronous to clk.
- REQ-007: i2s_sdata  input  1  is the external serial data from the pad, MSB first, asynchronous to clk.
- REQ-008: sample_l  output  WIDTH  is the left sample of the last delivered frame.
- REQ-009: sample_r  output  WIDTH  is the right sample of the last delivered frame.
- REQ-010: valid  output  1  indicates that the sample pair is available.
- REQ-011: ready  input  1  indicates that the consumer accepts the pair; a transfer occurs when valid and ready are both 1.
- REQ-012: overflow  output  1  is a sticky flag that a completed frame was dropped.
- REQ-013: overflow_clr  input  1  is a single-cycle pulse that clears overflow.

Function
- REQ-014: i2s_sclk, i2s_lrclk and i2s_sdata SHALL each pass through an identical 2-flop synchroniser; a sclk rising edge is detected when the synchronised value is 1 and its previous value was 0.
- REQ-015: All capture actions SHALL occur only in the clk cycle of a detected sclk rising edge, using the synchronised lrclk and sdata from that same cycle.
- REQ-016: Operation SHALL be guaranteed for clk >= 4x sclk, with sclk high and low each lasting >= 2 clk periods.
- REQ-017: An lrclk change SHALL be detected by comparing the lrclk sampled at the current sclk rising edge with the lrclk sampled at the previous one.
- REQ-018: Standard I2S framing with one-bit delay SHALL apply: the data bit sampled at the edge where a change is detected is the LSB slot of the ending word, and the next edge carries the MSB of the new word.
- REQ-019: A saturating bit counter (0..WIDTH) per word SHALL control capture; bit n (n < WIDTH) is stored at position WIDTH-1-n, and bits at n >= WIDTH are ignored.
- REQ-020: Words shorter than WIDTH SHALL leave their unfilled LSBs at 0, because the shift register is cleared at every word start.
- REQ-021: The state machine SHALL have three states, SYNC, LEFT and RIGHT, and SHALL reset to SYNC.
- REQ-022: In SYNC, the receiver SHALL wait for a detected lrclk change 1->0, then go to LEFT with the counter at 0; data before that change is discarded.
- REQ-023: On an lrclk change 0->1 in LEFT, the receiver SHALL latch the left word into an internal holding register and go to RIGHT.
- REQ-024: On an lrclk change 1->0 in RIGHT, the receiver SHALL complete the frame (holding register -> sample_l, right word -> sample_r) and go to LEFT.
- REQ-025: If a frame completes while valid=0, or while valid=1 and ready=1 in the same cycle, sample_l/sample_r SHALL be loaded and valid SHALL be 1 in the next cycle.
- REQ-026: If a frame completes while valid=1 and ready=0, the new frame SHALL be dropped, the old pair and valid retained, and overflow set.
- REQ-027: When valid=1 and ready=1 with no frame completing, valid SHALL be 0 in the next cycle.
- REQ-028: sample_l and sample_r SHALL be stable while valid=1.
- REQ-029: Latency SHALL be fixed: valid=1 after the 2nd clk edge following the clk edge that first registers the frame-completing sclk high into the first synchroniser stage.
- REQ-030: overflow_clr SHALL clear overflow in the next cycle; if a set and a clear coincide, the set SHALL win.
- REQ-031: en=0 SHALL force SYNC and clear the counter, holding register and shift register, while valid, the samples and overflow keep their handshake behaviour.
- REQ-032: A 0->1 lrclk change seen in SYNC, or an lrclk change whose direction does not match the state, SHALL cause no capture.

Reset
- REQ-033: arstn=0 SHALL immediately clear all synchronisers, counters, shift and holding registers, state=SYNC, sample_l=0, sample_r=0, valid=0 and overflow=0.
- REQ-034: A reset mid-frame SHALL discard the partial frame, and after release the first delivered frame SHALL be the first complete left/right pair following a 1->0 lrclk change.

Verification
- REQ-035: WIDTH=16, 32 sclk/frame, clk = 8x sclk, en=1, ready=1, frames L=0xA5C3/R=0x1234 -> first frame after SYNC dropped, then sample_l=0xA5C3, sample_r=0x1234, valid pulses for 1 cycle per frame.
- REQ-036: WIDTH=16, 24-bit slots carrying L=0xABCDEF/R=0x123456 -> sample_l=0xABCD, sample_r=0x1234.
- REQ-037: WIDTH=16, 8-bit slots carrying L=0xAB/R=0xCD -> sample_l=0xAB00, sample_r=0xCD00.
- REQ-038: ready=0 over two completed frames F1, F2 -> valid=1, sample pair=F1, overflow=1; then overflow_clr pulse -> overflow=0; then ready=1 -> F1 is transferred.
- REQ-039: arstn pulsed low mid-left word -> all outputs 0 immediately; no pair is delivered until a full frame follows a 1->0 lrclk change.
- REQ-040: A frame completes in the same cycle as valid=1 and ready=1 -> the new pair is loaded, valid stays 1, overflow stays 0.
